// File: rtl/tiger_round_unit.sv
// tiger_round_unit: one Tiger round step driving four registered S-box ROMs.
// Optional TIGER_ROUND_ERR_EN adds a sticky o_err for starts seen while busy.
module tiger_round_unit #(
  parameter int DLY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [63:0] i_c,
  input  logic [63:0] i_x,
  input  logic [1:0]  i_mul,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_a,
  output logic [63:0] o_b,
  output logic [63:0] o_c,
  output logic [7:0]  o_t1_addr,
  output logic [7:0]  o_t2_addr,
  output logic [7:0]  o_t3_addr,
  output logic [7:0]  o_t4_addr,
  input  logic [63:0] i_t1_data,
  input  logic [63:0] i_t2_data,
  input  logic [63:0] i_t3_data,
  input  logic [63:0] i_t4_data
`ifdef TIGER_ROUND_ERR_EN
  ,
  output logic        o_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LKA,
    S_LKB,
    S_ACB,
    S_MUL,
    S_DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [63:0] c_q;
  logic [1:0]  mul_q;
  logic [63:0] sbox_x;
  logic [63:0] b_mul;

  // DLY only matters to simulation wrappers; this RTL is zero-delay.
  logic unused_dly;
  assign unused_dly = ^DLY;

  assign sbox_x = i_t1_data ^ i_t2_data ^ i_t3_data ^ i_t4_data;

  assign o_busy = (state_q != S_IDLE);
  assign o_done = (state_q == S_DONE);

  always_comb begin
    unique case (mul_q)
      2'd1:    b_mul = (b_q << 3) - b_q;
      2'd2:    b_mul = (b_q << 3) + b_q;
      default: b_mul = (b_q << 2) + b_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    o_t1_addr = 8'd0;
    o_t2_addr = 8'd0;
    o_t3_addr = 8'd0;
    o_t4_addr = 8'd0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_LKA;
      end
      S_LKA: begin
        o_t1_addr = c_q[7:0];
        o_t2_addr = c_q[23:16];
        o_t3_addr = c_q[39:32];
        o_t4_addr = c_q[55:48];
        state_d   = S_LKB;
      end
      S_LKB: begin
        o_t1_addr = c_q[63:56];
        o_t2_addr = c_q[47:40];
        o_t3_addr = c_q[31:24];
        o_t4_addr = c_q[15:8];
        state_d   = S_ACB;
      end
      S_ACB:   state_d = S_MUL;
      S_MUL:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      mul_q <= '0;
      o_a   <= '0;
      o_b   <= '0;
      o_c   <= '0;
    end else begin
      if (state_q == S_IDLE && i_start) begin
        a_q   <= i_a;
        b_q   <= i_b;
        c_q   <= i_c ^ i_x;
        mul_q <= i_mul;
      end
      if (state_q == S_LKB) a_q <= a_q - sbox_x;
      if (state_q == S_ACB) b_q <= b_q + sbox_x;
      // Results publish on the edge that enters DONE.
      if (state_q == S_MUL) begin
        b_q <= b_mul;
        o_a <= a_q;
        o_b <= b_mul;
        o_c <= c_q;
      end
    end
  end

`ifdef TIGER_ROUND_ERR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if (i_start) begin
      o_err <= (state_q != S_IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_tiger_round_unit.sv
// tb_tiger_round_unit: scoreboard bench for tiger_round_unit.
// Registered ROM models feed the DUT; a monitor checks every o_done.
module tb_tiger_round_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [63:0] c = '0;
  logic [63:0] x = '0;
  logic [1:0]  mul = '0;
  logic        busy;
  logic        done;
  logic [63:0] oa;
  logic [63:0] ob;
  logic [63:0] oc;
  logic [7:0]  ad1;
  logic [7:0]  ad2;
  logic [7:0]  ad3;
  logic [7:0]  ad4;
  logic [63:0] d1 = '0;
  logic [63:0] d2 = '0;
  logic [63:0] d3 = '0;
  logic [63:0] d4 = '0;
`ifdef TIGER_ROUND_ERR_EN
  logic        err;
`endif

  logic [63:0] rom1 [256];
  logic [63:0] rom2 [256];
  logic [63:0] rom3 [256];
  logic [63:0] rom4 [256];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;

  tiger_round_unit #(.DLY(1)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_a       (a),
    .i_b       (b),
    .i_c       (c),
    .i_x       (x),
    .i_mul     (mul),
    .o_busy    (busy),
    .o_done    (done),
    .o_a       (oa),
    .o_b       (ob),
    .o_c       (oc),
    .o_t1_addr (ad1),
    .o_t2_addr (ad2),
    .o_t3_addr (ad3),
    .o_t4_addr (ad4),
    .i_t1_data (d1),
    .i_t2_data (d2),
    .i_t3_data (d3),
    .i_t4_data (d4)
`ifdef TIGER_ROUND_ERR_EN
    ,
    .o_err     (err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= rom1[ad1];
    d2 <= rom2[ad2];
    d3 <= rom3[ad3];
    d4 <= rom4[ad4];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty queue");
      end else begin
        mon_e = exp_q.pop_front();
        chk("o_a", oa, mon_e.a);
        chk("o_b", ob, mon_e.b);
        chk("o_c", oc, mon_e.c);
      end
    end
  end

  function automatic logic [7:0] byte_of(input logic [63:0] v, input int k);
    return 8'(v >> (8 * k));
  endfunction

  function automatic void model(input logic [63:0] ia, ib, ic, ix,
                                input logic [1:0] im,
                                output logic [63:0] ea, eb, ec);
    logic [63:0] cc;
    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] k;
    cc = ic ^ ix;
    sa = rom1[byte_of(cc, 0)] ^ rom2[byte_of(cc, 2)]
       ^ rom3[byte_of(cc, 4)] ^ rom4[byte_of(cc, 6)];
    sb = rom4[byte_of(cc, 1)] ^ rom3[byte_of(cc, 3)]
       ^ rom2[byte_of(cc, 5)] ^ rom1[byte_of(cc, 7)];
    k = (im == 2'd1) ? 64'd7 : (im == 2'd2) ? 64'd9 : 64'd5;
    ea = ia - sa;
    eb = (ib + sb) * k;
    ec = cc;
  endfunction

  task automatic run_op(input logic [63:0] ia, ib, ic, ix,
                        input logic [1:0] im,
                        input logic [63:0] ea, eb, ec, input bit poke);
    logic [63:0] cc;
    res_t        r;
    int          lat;
    cc = ic ^ ix;
    chk("idle_busy", 64'(busy), 64'd0);
    a = ia; b = ib; c = ic; x = ix; mul = im; start = 1'b1;
    r.a = ea; r.b = eb; r.c = ec;
    exp_q.push_back(r);
    lat = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        c = {$urandom, $urandom};
        x = {$urandom, $urandom};
        mul = 2'($urandom);
        chk("run_busy", 64'(busy), 64'd1);
        chk("lka_addr", 64'({ad1, ad2, ad3, ad4}),
            64'({byte_of(cc, 0), byte_of(cc, 2), byte_of(cc, 4), byte_of(cc, 6)}));
      end
      if (cyc == 2) begin
        chk("lkb_addr", 64'({ad1, ad2, ad3, ad4}),
            64'({byte_of(cc, 7), byte_of(cc, 5), byte_of(cc, 3), byte_of(cc, 1)}));
        if (poke) start = 1'b1;
      end
      if (cyc == 3) begin
        start = 1'b0;
        chk("acb_addr", 64'({ad1, ad2, ad3, ad4}), 64'd0);
      end
      if (done) begin
        lat = cyc;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd5);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] ec;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] rc;
    logic [63:0] rx;
    logic [1:0]  rm;
    int          dn;

    for (int i = 0; i < 256; i++) begin
      rom1[i] = '0;
      rom2[i] = '0;
      rom3[i] = '0;
      rom4[i] = 64'(i);
    end

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_oa", oa, 64'd0);
    chk("rst_ob", ob, 64'd0);
    chk("rst_oc", oc, 64'd0);
    chk("rst_addr", 64'({ad1, ad2, ad3, ad4}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(64'd10, 64'd0, 64'h0706050403020100, 64'd0, 2'd0,
           64'd4, 64'd5, 64'h0706050403020100, 1'b0);
    run_op(64'd0, 64'd2, 64'd0, 64'h300, 2'd1,
           64'd0, 64'd35, 64'h300, 1'b0);
    run_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0006000000000100, 64'd0, 2'd2,
           64'hFFFF_FFFF_FFFF_FFFA, 64'd0, 64'h0006000000000100, 1'b0);
    run_op(64'h1000, 64'd0, 64'h8877665544332211, 64'd0, 2'd0,
           64'hF89, 64'hAA, 64'h8877665544332211, 1'b0);
    run_op(64'd0, 64'd1, 64'h100, 64'd0, 2'd3,
           64'd0, 64'd10, 64'h100, 1'b0);

    dn = n_done;
    run_op(64'd5, 64'd5, 64'd0, 64'd0, 2'd0,
           64'd5, 64'd25, 64'd0, 1'b1);
    repeat (8) @(negedge clk);
    chk("single_done", 64'(n_done - dn), 64'd1);
    chk("hold_oa", oa, 64'd5);
    chk("hold_ob", ob, 64'd25);
`ifdef TIGER_ROUND_ERR_EN
    chk("err_set", 64'(err), 64'd1);
`endif
    run_op(64'd7, 64'd1, 64'd0, 64'd0, 2'd1,
           64'd7, 64'd7, 64'd0, 1'b0);
`ifdef TIGER_ROUND_ERR_EN
    chk("err_clear", 64'(err), 64'd0);
`endif

    dn = n_done;
    a = 64'd99; b = 64'd3; c = 64'h0102030405060708; x = 64'd0; mul = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_oa", oa, 64'd0);
    chk("midrst_ob", ob, 64'd0);
    chk("midrst_oc", oc, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_addr", 64'({ad1, ad2, ad3, ad4}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_nodone", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_count", 64'(n_done - dn), 64'd0);
    run_op(64'd10, 64'd0, 64'h0706050403020100, 64'd0, 2'd0,
           64'd4, 64'd5, 64'h0706050403020100, 1'b0);

    for (int i = 0; i < 256; i++) begin
      rom1[i] = {$urandom, $urandom};
      rom2[i] = {$urandom, $urandom};
      rom3[i] = {$urandom, $urandom};
      rom4[i] = {$urandom, $urandom};
    end
    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      rx = {$urandom, $urandom};
      rm = 2'($urandom_range(0, 3));
      model(ra, rb, rc, rx, rm, ea, eb, ec);
      run_op(ra, rb, rc, rx, rm, ea, eb, ec, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
